serial_pattern_sequencer: RTL and testbench

- Controller that feeds the serial pattern-detector FSM (input w, output out) from a parallel word, one bit per clock, MSB first.
- Gates the detector with a per-bit enable and clears its state before each run.
- Collects the detector's hit flags and reports the hit count and the bit index of the first hit.
- Sits between a parallel producer and the detector; the detector is external, connected through w_out, det_en, det_clr and det_hit.

---
 rtl/serial_pattern_sequencer_if.sv | 28 ++
 rtl/serial_pattern_sequencer.sv | 146 ++++++++++++++
 tb/tb_serial_pattern_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_sequencer_if.sv
// Producer-side bus of the serial pattern sequencer.
//   start, data_in, len          : run request from the producer
//   busy, done, err              : run status back to the producer
//   hit_count, first_hit_pos     : results of the last completed run
// modport master: producer side; modport slave: sequencer side.
interface serial_pattern_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] first_hit_pos;

    modport master (
        output start, data_in, len,
        input  busy, done, err, hit_count, first_hit_pos
    );

    modport slave (
        input  start, data_in, len,
        output busy, done, err, hit_count, first_hit_pos
    );
endinterface

// File: rtl/serial_pattern_sequencer.sv
// Serialises a parallel word MSB first into an external pattern detector,
// gates it with det_en, clears it before each run and collects its hits.
//   clk, reset   : system clock, asynchronous active-high reset
//   bus (slave)  : start/data_in/len request, busy/done/err status,
//                  hit_count/first_hit_pos results
//   w_out        : serial bit to the detector
//   det_en       : w_out carries a valid bit
//   det_clr      : clears the detector, asserted in the accepting cycle
//   det_hit      : detector hit flag, DET_LAT clocks behind w_out
module serial_pattern_sequencer #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 5,
    parameter int DET_LAT = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    serial_pattern_sequencer_if.slave   bus,
    input  logic                        det_hit,
    output logic                        w_out,
    output logic                        det_en,
    output logic                        det_clr
);
    localparam int KW = CNT_W + 2;
    localparam logic [CNT_W-1:0] LEN_MAX    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ALL_ONES   = '1;
    localparam logic [1:0]       DRAIN_LOAD = (DET_LAT > 0) ? 2'(DET_LAT - 1) : 2'd0;
    localparam logic [KW-1:0]    LAT_K      = KW'(DET_LAT);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] bits_left;
    logic [1:0]       drain_left;
    logic [KW-1:0]    k;            // cycles since the first SHIFT cycle
    logic [CNT_W-1:0] hit_count_r;
    logic [CNT_W-1:0] first_hit_r;
    logic             err_r;

    logic             len_ok;
    logic             accept;
    logic             sample_ok;
    logic [CNT_W-1:0] hit_idx;
    logic             busy_c;
    logic             done_c;

    assign len_ok    = (bus.len != '0) && (bus.len <= LEN_MAX);
    assign accept    = (state == IDLE) && bus.start && len_ok;
    // A hit seen k cycles into the run belongs to bit k-DET_LAT; earlier
    // samples still reflect the detector's cleared pipeline.
    assign sample_ok = ((state == SHIFT) || (state == DRAIN)) && (k >= LAT_K);
    assign hit_idx   = CNT_W'(k - LAT_K);

    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.err           = err_r;
    assign bus.hit_count     = hit_count_r;
    assign bus.first_hit_pos = first_hit_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        w_out     = 1'b0;
        det_en    = 1'b0;
        det_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && len_ok) begin
                    state_nxt = SHIFT;
                    // Clear in the accepting cycle so the detector is clean
                    // on the edge before the first bit reaches it.
                    det_clr   = !reset;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                det_en = 1'b1;
                w_out  = sr[WIDTH-1];
                if (bits_left == CNT_W'(1))
                    state_nxt = (DET_LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (drain_left == 2'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr          <= '0;
            bits_left   <= '0;
            drain_left  <= '0;
            k           <= '0;
            hit_count_r <= '0;
            first_hit_r <= '1;
            err_r       <= 1'b0;
        end else begin
            err_r <= (state == IDLE) && bus.start && !len_ok;

            case (state)
                IDLE: begin
                    if (accept) begin
                        sr          <= bus.data_in;
                        bits_left   <= bus.len;
                        drain_left  <= DRAIN_LOAD;
                        k           <= '0;
                        hit_count_r <= '0;
                        first_hit_r <= '1;
                    end
                end
                SHIFT: begin
                    sr        <= {sr[WIDTH-2:0], 1'b0};
                    bits_left <= bits_left - CNT_W'(1);
                    k         <= k + KW'(1);
                end
                DRAIN: begin
                    drain_left <= drain_left - 2'd1;
                    k          <= k + KW'(1);
                end
                default: ;
            endcase

            if (sample_ok && det_hit) begin
                if (hit_count_r != ALL_ONES)
                    hit_count_r <= hit_count_r + CNT_W'(1);
                if (first_hit_r == ALL_ONES)
                    first_hit_r <= hit_idx;
            end
        end
    end
endmodule

// File: tb/tb_serial_pattern_sequencer.sv
module tb_serial_pattern_sequencer;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_pattern_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus0 ();
    serial_pattern_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus1 ();

    logic        start;
    logic [15:0] data_v;
    logic [4:0]  len_v;
    logic        hit0_drv, hit1_drv, use_pat;
    logic        det_hit0, det_hit1;
    logic        w0, w1, en0, en1, clr0, clr1;
    logic        det_q;
    logic [3:0]  hist;

    assign bus0.start   = start;
    assign bus0.data_in = data_v;
    assign bus0.len     = len_v;
    assign bus1.start   = start;
    assign bus1.data_in = data_v;
    assign bus1.len     = len_v;

    assign det_hit0 = hit0_drv;
    assign det_hit1 = use_pat ? det_q : hit1_drv;

    serial_pattern_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DET_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .det_hit(det_hit0),
        .w_out(w0), .det_en(en0), .det_clr(clr0)
    );

    serial_pattern_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DET_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .det_hit(det_hit1),
        .w_out(w1), .det_en(en1), .det_clr(clr1)
    );

    // External "0011" detector for dut1, one clock of latency.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            det_q <= 1'b0;
        end else if (clr1) begin
            hist  <= '0;
            det_q <= 1'b0;
        end else if (en1) begin
            hist  <= {hist[2:0], w1};
            det_q <= ({hist[2:0], w1} == 4'b0011);
        end else begin
            det_q <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit legal(input logic [4:0] l);
        return (int'(l) >= 1) && (int'(l) <= WIDTH);
    endfunction

    // Reference model: a run is a timeline of offsets after acceptance.
    // Offset n in 1..len carries bit n-1, offsets up to len+L are busy,
    // offset len+L+1 is the done cycle. Index i of the arrays is also L.
    int          n_m[2];
    logic [15:0] d_m[2];
    int          len_m[2];
    int          cnt_m[2];
    int          first_m[2];
    logic        err_m[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                n_m[i]     <= 0;
                cnt_m[i]   <= 0;
                first_m[i] <= 31;
                err_m[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic h;
                int   idx;
                h = (i == 0) ? det_hit0 : det_hit1;
                idx = n_m[i] - 1 - i;
                err_m[i] <= 1'b0;
                if (n_m[i] == 0) begin
                    if (start) begin
                        if (legal(len_v)) begin
                            n_m[i]     <= 1;
                            d_m[i]     <= data_v;
                            len_m[i]   <= int'(len_v);
                            cnt_m[i]   <= 0;
                            first_m[i] <= 31;
                        end else begin
                            err_m[i] <= 1'b1;
                        end
                    end
                end else if (n_m[i] <= len_m[i] + i) begin
                    if (h && idx >= 0) begin
                        cnt_m[i] <= (cnt_m[i] < 31) ? cnt_m[i] + 1 : 31;
                        if (first_m[i] == 31)
                            first_m[i] <= idx;
                    end
                    n_m[i] <= n_m[i] + 1;
                end else begin
                    n_m[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int nn, ln, w_e;
            bit bz, en_e, dn, cl;
            nn   = n_m[i];
            ln   = len_m[i];
            bz   = (nn >= 1) && (nn <= ln + i);
            en_e = (nn >= 1) && (nn <= ln);
            dn   = (nn != 0) && (nn == ln + i + 1);
            w_e  = 0;
            if (en_e)
                w_e = int'(d_m[i][16 - nn]);
            cl   = !reset && (nn == 0) && start && legal(len_v);
            if (i == 0) begin
                chk("dut0.busy",  int'(bus0.busy), int'(bz));
                chk("dut0.done",  int'(bus0.done), int'(dn));
                chk("dut0.err",   int'(bus0.err),  int'(err_m[0]));
                chk("dut0.det_en", int'(en0), int'(en_e));
                chk("dut0.w_out", int'(w0), w_e);
                chk("dut0.det_clr", int'(clr0), int'(cl));
                chk("dut0.hit_count", int'(bus0.hit_count), cnt_m[0]);
                chk("dut0.first_hit_pos", int'(bus0.first_hit_pos), first_m[0]);
            end else begin
                chk("dut1.busy",  int'(bus1.busy), int'(bz));
                chk("dut1.done",  int'(bus1.done), int'(dn));
                chk("dut1.err",   int'(bus1.err),  int'(err_m[1]));
                chk("dut1.det_en", int'(en1), int'(en_e));
                chk("dut1.w_out", int'(w1), w_e);
                chk("dut1.det_clr", int'(clr1), int'(cl));
                chk("dut1.hit_count", int'(bus1.hit_count), cnt_m[1]);
                chk("dut1.first_hit_pos", int'(bus1.first_hit_pos), first_m[1]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          r_d0_at, r_d1_at, r_d0_n, r_d1_n, r_busy0, r_busy1, r_nw1, r_clr0, r_clr1;
    logic [15:0] r_w1;

    // Starts a run from IDLE and watches both DUTs until well past done.
    task automatic run(input logic [15:0] d, input logic [4:0] l, input int mid);
        start  = 1'b1;
        data_v = d;
        len_v  = l;
        #1;
        r_clr0 = int'(clr0);
        r_clr1 = int'(clr1);
        step();
        start   = 1'b0;
        r_d0_at = -1; r_d1_at = -1; r_d0_n = 0; r_d1_n = 0;
        r_busy0 = 0;  r_busy1 = 0;  r_nw1 = 0;  r_w1 = '0;
        for (int c = 1; c <= int'(l) + 5; c++) begin
            start = (c == mid);
            #1;
            if (bus0.done) begin r_d0_n++; if (r_d0_at < 0) r_d0_at = c; end
            if (bus1.done) begin r_d1_n++; if (r_d1_at < 0) r_d1_at = c; end
            if (bus0.busy) r_busy0++;
            if (bus1.busy) r_busy1++;
            if (en1) begin r_w1 = {r_w1[14:0], w1}; r_nw1++; end
            r_clr0 += int'(clr0);
            r_clr1 += int'(clr1);
            step();
        end
        start = 1'b0;
    endtask

    task automatic illegal(input logic [4:0] l, input int hc1, input int fp1);
        start  = 1'b1;
        len_v  = l;
        data_v = 16'($urandom);
        step();
        start = 1'b0;
        chk("err0_pulse", int'(bus0.err), 1);
        chk("err1_pulse", int'(bus1.err), 1);
        chk("err_busy1", int'(bus1.busy), 0);
        chk("err_keep_hits1", int'(bus1.hit_count), hc1);
        chk("err_keep_first1", int'(bus1.first_hit_pos), fp1);
        step();
        chk("err1_clear", int'(bus1.err), 0);
    endtask

    initial begin
        int dn;
        reset = 1'b1; start = 1'b0; data_v = '0; len_v = '0;
        hit0_drv = 1'b0; hit1_drv = 1'b0; use_pat = 1'b0;
        #1;
        chk("rst_first0", int'(bus0.first_hit_pos), 31);
        chk("rst_first1", int'(bus1.first_hit_pos), 31);
        chk("rst_hits1", int'(bus1.hit_count), 0);
        chk("rst_busy1", int'(bus1.busy), 0);
        repeat (2) step();
        reset = 1'b0;
        step();

        // 10011 into a "0011" detector with one clock of latency.
        use_pat = 1'b1;
        run(16'b1001100000000000, 5'd5, 0);
        chk("pat_wbits", int'(r_w1), 19);
        chk("pat_nbits", r_nw1, 5);
        chk("pat_busy", r_busy1, 6);
        chk("pat_done_at", r_d1_at, 7);
        chk("pat_clr", r_clr1, 1);
        chk("pat_hits", int'(bus1.hit_count), 1);
        chk("pat_first", int'(bus1.first_hit_pos), 4);
        use_pat = 1'b0;

        illegal(5'd0, 1, 4);
        illegal(5'd17, 1, 4);

        // start during a run is ignored.
        run(16'($urandom), 5'd8, 2);
        chk("mid_done0_at", r_d0_at, 9);
        chk("mid_done0_n", r_d0_n, 1);
        chk("mid_done1_at", r_d1_at, 10);
        chk("mid_done1_n", r_d1_n, 1);

        // det_hit stuck high, including IDLE and DONE.
        hit0_drv = 1'b1; hit1_drv = 1'b1;
        repeat (2) step();
        run(16'($urandom), 5'd16, 0);
        chk("full_busy0", r_busy0, 16);
        chk("full_done0_at", r_d0_at, 17);
        chk("full_hits0", int'(bus0.hit_count), 16);
        chk("full_first0", int'(bus0.first_hit_pos), 0);
        chk("full_hits1", int'(bus1.hit_count), 16);
        chk("full_first1", int'(bus1.first_hit_pos), 0);

        // Back-to-back: second run sees no hits.
        run(16'($urandom), 5'd6, 0);
        hit0_drv = 1'b0; hit1_drv = 1'b0;
        run(16'($urandom), 5'd7, 0);
        chk("b2b_hits0", int'(bus0.hit_count), 0);
        chk("b2b_first0", int'(bus0.first_hit_pos), 31);
        chk("b2b_first1", int'(bus1.first_hit_pos), 31);
        chk("b2b_clr0", r_clr0, 1);
        chk("b2b_clr1", r_clr1, 1);

        // Reset on the third bit of a run.
        hit1_drv = 1'b1;
        start = 1'b1; len_v = 5'd8; data_v = 16'hFFFF;
        step();
        start = 1'b0;
        repeat (2) step();
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_busy1", int'(bus1.busy), 0);
        chk("mrst_en1", int'(en1), 0);
        chk("mrst_w1", int'(w1), 0);
        chk("mrst_first1", int'(bus1.first_hit_pos), 31);
        chk("mrst_first0", int'(bus0.first_hit_pos), 31);
        repeat (2) step();
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            dn += int'(bus0.done) + int'(bus1.done);
            step();
        end
        chk("mrst_no_done", dn, 0);

        // Randomised traffic.
        for (int c = 0; c < 800; c++) begin
            int r;
            use_pat  = (c >= 400);
            start    = ($urandom_range(0, 3) == 0);
            data_v   = 16'($urandom);
            r        = int'($urandom_range(0, 9));
            if (r == 0)      len_v = 5'd0;
            else if (r == 1) len_v = 5'($urandom_range(17, 31));
            else             len_v = 5'($urandom_range(1, 16));
            hit0_drv = 1'($urandom_range(0, 1));
            hit1_drv = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        repeat (25) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
